// File: rtl/mem_arbiter.sv
// Purpose: two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter, round-robin on contention.
// Latency: a request seen in IDLE is forwarded on the next cycle; a response handshake returns to IDLE on the next cycle.
// Backpressure: no buffering; slave ready/valid is passed combinationally to the granted master, others see 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read address / read data channels
//   lsu_ar*/lsu_r*        LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b* LSU write address / write data / write response channels
//   mem_*                 slave-side mirror of all five channels
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,

    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,

    output logic                mem_arvalid,
    input  logic                mem_arready,
    output logic [ADDR_W-1:0]   mem_araddr,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_bvalid,
    output logic                mem_bready,
    input  logic [1:0]          mem_bresp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;       // 0: last grant to IFU, 1: last grant to LSU
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic ifu_req, lsu_wr, lsu_rd, lsu_req;

    assign ifu_req = ifu_arvalid;
    assign lsu_wr  = lsu_awvalid | lsu_wvalid;
    assign lsu_rd  = lsu_arvalid;
    assign lsu_req = lsu_wr | lsu_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        ar_done_d   = ar_done_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awvalid = 1'b0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;

        // Payload/response buses pass straight through; only the handshakes are gated.
        mem_araddr  = (state_q == RD_IFU) ? ifu_araddr : lsu_araddr;
        mem_awaddr  = lsu_awaddr;
        mem_wdata   = lsu_wdata;
        mem_wstrb   = lsu_wstrb;
        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        lsu_rdata   = mem_rdata;
        lsu_rresp   = mem_rresp;
        lsu_bresp   = mem_bresp;

        case (state_q)
            IDLE: begin
                if (ifu_req && (!lsu_req || last_q)) begin
                    state_d = RD_IFU;
                    last_d  = 1'b0;
                end else if (lsu_req) begin
                    state_d = lsu_wr ? WR_LSU : RD_LSU;
                    last_d  = 1'b1;
                end
            end

            RD_IFU: begin
                mem_arvalid = ifu_arvalid & ~ar_done_q;
                ifu_arready = mem_arready & ~ar_done_q;
                mem_rready  = ifu_rready;
                ifu_rvalid  = mem_rvalid;
                if (ifu_arvalid && mem_arready && !ar_done_q)
                    ar_done_d = 1'b1;
                // Exit on the response even if AR never completed.
                if (mem_rvalid && ifu_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end

            RD_LSU: begin
                mem_arvalid = lsu_arvalid & ~ar_done_q;
                lsu_arready = mem_arready & ~ar_done_q;
                mem_rready  = lsu_rready;
                lsu_rvalid  = mem_rvalid;
                if (lsu_arvalid && mem_arready && !ar_done_q)
                    ar_done_d = 1'b1;
                if (mem_rvalid && lsu_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end

            WR_LSU: begin
                // AW and W complete independently; each is forwarded until its own handshake.
                mem_awvalid = lsu_awvalid & ~aw_done_q;
                lsu_awready = mem_awready & ~aw_done_q;
                mem_wvalid  = lsu_wvalid & ~w_done_q;
                lsu_wready  = mem_wready & ~w_done_q;
                mem_bready  = lsu_bready;
                lsu_bvalid  = mem_bvalid;
                if (lsu_awvalid && mem_awready && !aw_done_q)
                    aw_done_d = 1'b1;
                if (lsu_wvalid && mem_wready && !w_done_q)
                    w_done_d = 1'b1;
                if (mem_bvalid && lsu_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
